// File: rtl/rcswitch_cmd_encoder_pkg.sv
// ---------------------------------------------------------------------------
// rcswitch_cmd_encoder_pkg
// Shared constants for the rcswitch command path: the tri-state pulse symbols,
// the fixed sync word, the status words and the encoder FSM state encodings.
// Also provides a helper that maps one DIP bit to its pulse symbol.
// ---------------------------------------------------------------------------
package rcswitch_cmd_encoder_pkg;

    // Pulse patterns for the two tri-state symbols used by the sockets
    localparam logic [7:0]  SYM_0     = 8'h88;
    localparam logic [7:0]  SYM_F     = 8'h8E;
    localparam logic [31:0] SYNC_WORD = 32'h8000_0000;
    localparam logic [15:0] STAT_ON   = 16'h8E88;
    localparam logic [15:0] STAT_OFF  = 16'h888E;

    // Encoder FSM states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_BUSY = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    // A set DIP switch is sent as '0', an open one as 'F'
    function automatic logic [7:0] sym_of(input logic dip_bit);
        return dip_bit ? SYM_0 : SYM_F;
    endfunction

endpackage

// File: rtl/rcswitch_cmd_encoder_tristate_enc.sv
// ---------------------------------------------------------------------------
// rcswitch_tristate_enc
// Purely combinational translation of a socket command into the tri-state
// pulse words understood by rcswitch_send. Kept separate so a receive-side
// comparator can rebuild the same words from a decoded command.
// Ports:
//   group_i   [4:0]  DIP code, bit 4 is the first symbol sent
//   chan_i    [2:0]  channel 0..4 (A..E); other values give all 'F' slots
//   on_i             1 = ON, 0 = OFF
//   addr_o   [39:0]  five address symbols, slot 0 in [39:32]
//   chan_o   [39:0]  five channel symbols, selected slot is '0'
//   stat_o   [15:0]  ON/OFF status word
// ---------------------------------------------------------------------------
module rcswitch_tristate_enc
    import rcswitch_cmd_encoder_pkg::*;
(
    input  logic [4:0]  group_i,
    input  logic [2:0]  chan_i,
    input  logic        on_i,
    output logic [39:0] addr_o,
    output logic [39:0] chan_o,
    output logic [15:0] stat_o
);

    // Build the address, channel and status words slot by slot
    always_comb begin
        addr_o = 40'h0;
        chan_o = 40'h0;
        for (int i = 0; i < 5; i++) begin
            addr_o[39 - 8*i -: 8] = sym_of(group_i[4 - i]);
            chan_o[39 - 8*i -: 8] = (chan_i == 3'(i)) ? SYM_0 : SYM_F;
        end
        if (on_i) begin
            stat_o = STAT_ON;
        end else begin
            stat_o = STAT_OFF;
        end
    end

endmodule

// File: rtl/rcswitch_cmd_encoder.sv
// ---------------------------------------------------------------------------
// rcswitch_cmd_encoder
// Command stage in front of rcswitch_send. Accepts a socket command, latches
// the encoded addr/chan/stat words, and runs REPEATS send/ready handshakes with
// GAP_CYCLES idle cycles between frames, ending with a done or err pulse.
// Optional feature macro: RCSWITCH_ABORT_EN adds the 'abort' input, which ends
// a command early (immediately in ARM/GAP, after the current frame in REQ/BUSY).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_group/cmd_chan/cmd_on    command fields
//   addr/chan/stat/sync          words for rcswitch_send, stable between accepts
//   send/ready                   handshake with rcswitch_send (ready=1: idle)
//   done/err                     one-cycle completion / failure pulses
//   abort                        (RCSWITCH_ABORT_EN only) early termination
// ---------------------------------------------------------------------------
module rcswitch_cmd_encoder
    import rcswitch_cmd_encoder_pkg::*;
#(
    parameter int REPEATS     = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_group,
    input  logic [2:0]  cmd_chan,
    input  logic        cmd_on,
    output logic [39:0] addr,
    output logic [39:0] chan,
    output logic [15:0] stat,
    output logic [31:0] sync,
    output logic        send,
    input  logic        ready,
    output logic        done,
    output logic        err
`ifdef RCSWITCH_ABORT_EN
    ,
    input  logic        abort
`endif
);

    localparam int REP_W = $clog2(REPEATS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEATS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             send_q, send_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [39:0]      addr_q, chan_q;
    logic [15:0]      stat_q;
    logic             load_s;
    logic             abort_s;
    logic [39:0]      enc_addr_s, enc_chan_s;
    logic [15:0]      enc_stat_s;

`ifdef RCSWITCH_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    rcswitch_tristate_enc u_enc (
        .group_i (cmd_group),
        .chan_i  (cmd_chan),
        .on_i    (cmd_on),
        .addr_o  (enc_addr_s),
        .chan_o  (enc_chan_s),
        .stat_o  (enc_stat_s)
    );

    // Next-state logic for the send/repeat FSM
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        pend_d  = pend_q;
        send_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_chan <= 3'd4) begin
                        load_s  = 1'b1;
                        rep_d   = '0;
                        tmo_d   = '0;
                        pend_d  = 1'b0;
                        state_d = ST_ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (abort_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (ready) begin
                    send_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_REQ: begin
                // An abort here only cancels the remaining repeats
                if (abort_s) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (!ready) begin
                    state_d = ST_BUSY;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    send_d = 1'b1;
                    tmo_d  = tmo_q + TMO_W'(1);
                end
            end
            ST_BUSY: begin
                if (abort_s) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (ready) begin
                    if ((rep_q == REP_LAST) || pend_d) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rep_d   = rep_q + REP_W'(1);
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_GAP: begin
                if (abort_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    tmo_d   = '0;
                    state_d = ST_ARM;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rep_q   <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            send_q  <= send_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    // Frame words are captured only on a valid accept and held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 40'h0;
            chan_q <= 40'h0;
            stat_q <= 16'h0;
        end else if (load_s) begin
            addr_q <= enc_addr_s;
            chan_q <= enc_chan_s;
            stat_q <= enc_stat_s;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign addr      = addr_q;
    assign chan      = chan_q;
    assign stat      = stat_q;
    assign sync      = SYNC_WORD;
    assign send      = send_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
